// File: rtl/ecg_pkg.sv
// Shared types and default widths for the ECG generator / R-peak detector pair.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ecg_pkg;

    localparam int ECG_DATA_W = 16;
    localparam int ECG_CNT_W  = 16;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        PEAK    = 2'd1,
        REFRACT = 2'd2
    } det_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and parallel load (clear > load > inc).
// Latency: new value visible one clk after the controlling input.
// Backpressure: none; inc is a qualified enable and the count holds when it is low.
module sat_counter #(
    parameter int             W   = 16,
    parameter logic [W-1:0]   MAX = '1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] cnt,
    output logic         at_max
);

    logic [W-1:0] cnt_d;
    logic [W-1:0] cnt_q;

    // next count: clear wins, then load, then a saturating increment
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = load_val;
        end else if (inc && (cnt_q != MAX)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt    = cnt_q;
    assign at_max = (cnt_q == MAX);

endmodule

// File: rtl/ecg_rpeak_detector.sv
// R-peak detector: hysteresis thresholds, peak tracking, refractory hold-off, interval and loss reporting.
// Latency: beat_pulse and beat outputs update 1 clk after the releasing valid sample.
// Backpressure: none; sample_valid qualifies input, every register holds while it is low.
module ecg_rpeak_detector
    import ecg_pkg::*;
#(
    parameter int DATA_W          = ECG_DATA_W,
    parameter int CNT_W           = ECG_CNT_W,
    parameter int REFRACT_SAMPLES = 64,
    parameter int PERIOD_MAX      = 65535
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] thresh_hi,
    input  logic [DATA_W-1:0] thresh_lo,
    output logic              beat_pulse,
    output logic [DATA_W-1:0] peak_value,
    output logic [CNT_W-1:0]  beat_period,
    output logic              period_valid,
    output logic              lost
);

    localparam int               RFR_W    = (REFRACT_SAMPLES > 1) ? $clog2(REFRACT_SAMPLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(PERIOD_MAX);
    localparam logic [CNT_W-1:0] CNT_LOST = CNT_W'(PERIOD_MAX - 1);
    localparam logic [RFR_W-1:0] RFR_LAST = RFR_W'(REFRACT_SAMPLES - 1);

    det_state_e        state_d, state_q;
    logic [DATA_W-1:0] cand_max_d, cand_max_q;
    logic [CNT_W-1:0]  cand_pos_d, cand_pos_q;
    logic              first_beat_d, first_beat_q;
    logic              beat_pulse_d, beat_pulse_q;
    logic [DATA_W-1:0] peak_value_d, peak_value_q;
    logic [CNT_W-1:0]  beat_period_d, beat_period_q;
    logic              period_valid_d, period_valid_q;
    logic              lost_d, lost_q;

    logic              confirm;
    logic [CNT_W-1:0]  ivl_cnt;
    logic              ivl_at_max;
    logic [CNT_W-1:0]  cnt_inc;
    logic [RFR_W-1:0]  refr_cnt_unused;
    logic              refr_at_max;
    logic              refr_inc;

    // samples since the last confirmed peak maximum; rebased onto the peak at confirm
    sat_counter #(.W(CNT_W), .MAX(CNT_MAX)) u_ivl_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .inc      (sample_valid),
        .load     (confirm),
        .load_val (cnt_inc - cand_pos_q),
        .cnt      (ivl_cnt),
        .at_max   (ivl_at_max)
    );

    // refractory hold-off; at_max marks the last ignored sample
    assign refr_inc = sample_valid && (state_q == REFRACT) && !clr;

    sat_counter #(.W(RFR_W), .MAX(RFR_LAST)) u_refr_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr || confirm),
        .inc      (refr_inc),
        .load     (1'b0),
        .load_val ('0),
        .cnt      (refr_cnt_unused),
        .at_max   (refr_at_max)
    );

    // position of the sample being consumed, saturating with the interval counter
    assign cnt_inc = ivl_at_max ? ivl_cnt : (ivl_cnt + CNT_W'(1));

    // detection FSM and beat reporting, advanced only by valid samples
    always_comb begin
        state_d        = state_q;
        cand_max_d     = cand_max_q;
        cand_pos_d     = cand_pos_q;
        first_beat_d   = first_beat_q;
        beat_pulse_d   = 1'b0;
        peak_value_d   = peak_value_q;
        beat_period_d  = beat_period_q;
        period_valid_d = period_valid_q;
        lost_d         = lost_q;
        confirm        = 1'b0;

        if (clr) begin
            state_d        = SEARCH;
            cand_max_d     = '0;
            cand_pos_d     = '0;
            first_beat_d   = 1'b1;
            peak_value_d   = '0;
            beat_period_d  = '0;
            period_valid_d = 1'b0;
            lost_d         = 1'b0;
        end else if (sample_valid) begin
            case (state_q)
                SEARCH: begin
                    if ($signed(sample_in) >= $signed(thresh_hi)) begin
                        state_d    = PEAK;
                        cand_max_d = sample_in;
                        cand_pos_d = cnt_inc;
                    end
                end
                PEAK: begin
                    // a new maximum never releases; ties keep the earlier position
                    if ($signed(sample_in) > $signed(cand_max_q)) begin
                        cand_max_d = sample_in;
                        cand_pos_d = cnt_inc;
                    end else if ($signed(sample_in) < $signed(thresh_lo)) begin
                        confirm = 1'b1;
                    end
                end
                REFRACT: begin
                    if (refr_at_max) begin
                        state_d = SEARCH;
                    end
                end
                default: state_d = SEARCH;
            endcase

            // interval counter reaching its ceiling: signal lost, next beat restarts the interval
            if (!confirm && (ivl_cnt == CNT_LOST)) begin
                lost_d         = 1'b1;
                period_valid_d = 1'b0;
                first_beat_d   = 1'b1;
            end

            if (confirm) begin
                beat_pulse_d = 1'b1;
                peak_value_d = cand_max_q;
                lost_d       = 1'b0;
                state_d      = REFRACT;
                if (first_beat_q) begin
                    first_beat_d = 1'b0;
                end else begin
                    beat_period_d  = cand_pos_q;
                    period_valid_d = 1'b1;
                end
            end
        end
    end

    // state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= SEARCH;
            cand_max_q     <= '0;
            cand_pos_q     <= '0;
            first_beat_q   <= 1'b1;
            beat_pulse_q   <= 1'b0;
            peak_value_q   <= '0;
            beat_period_q  <= '0;
            period_valid_q <= 1'b0;
            lost_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            cand_max_q     <= cand_max_d;
            cand_pos_q     <= cand_pos_d;
            first_beat_q   <= first_beat_d;
            beat_pulse_q   <= beat_pulse_d;
            peak_value_q   <= peak_value_d;
            beat_period_q  <= beat_period_d;
            period_valid_q <= period_valid_d;
            lost_q         <= lost_d;
        end
    end

    assign beat_pulse   = beat_pulse_q;
    assign peak_value   = peak_value_q;
    assign beat_period  = beat_period_q;
    assign period_valid = period_valid_q;
    assign lost         = lost_q;

endmodule

// File: tb/tb_ecg_rpeak_detector.sv
// Bench for ecg_rpeak_detector: scripted ECG-like stimulus, expected beats queued at the releasing sample.
// Latency: expects each beat_pulse exactly one clk after its releasing sample.
// Backpressure: none; sample_valid gaps are inserted to exercise hold behaviour.
module tb_ecg_rpeak_detector;

    typedef logic [15:0] sq_t[$];

    typedef struct {
        logic [15:0] peak;
        logic [15:0] period;
        logic        pv;
        int          at;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr;
    logic [15:0] sample_in;
    logic        sample_valid;
    logic [15:0] thresh_hi;
    logic [15:0] thresh_lo;
    logic        beat_pulse;
    logic [15:0] peak_value;
    logic [15:0] beat_period;
    logic        period_valid;
    logic        lost;

    ecg_rpeak_detector #(
        .DATA_W          (16),
        .CNT_W           (16),
        .REFRACT_SAMPLES (64),
        .PERIOD_MAX      (65535)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr          (clr),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .thresh_hi    (thresh_hi),
        .thresh_lo    (thresh_lo),
        .beat_pulse   (beat_pulse),
        .peak_value   (peak_value),
        .beat_period  (beat_period),
        .period_valid (period_valid),
        .lost         (lost)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int   checks = 0;
    int   fails  = 0;
    exp_t sb[$];

    // bench-side bookkeeping of where peaks were placed
    int          vidx;
    int          last_pk;
    int          pk;
    bit          first;
    logic [15:0] exp_period;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=0x%0h exp=0x%0h @cyc %0d", tag, got, exp, cyc);
        end
    endtask

    // every pulse must be expected, single-cycle and on time
    logic prev_pulse = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (beat_pulse === 1'b1) begin
            chk("pulse_width", {31'd0, prev_pulse}, 32'd0);
            chk("sb_nonempty_at_pulse", {31'd0, (sb.size() > 0)}, 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("peak_value",   {16'd0, peak_value},  {16'd0, e.peak});
                chk("beat_period",  {16'd0, beat_period}, {16'd0, e.period});
                chk("period_valid", {31'd0, period_valid}, {31'd0, e.pv});
                chk("lost_at_beat", {31'd0, lost}, 32'd0);
                chk("pulse_latency", cyc, e.at);
            end
        end
        prev_pulse = beat_pulse;
    end

    task automatic put(input logic [15:0] s, input bit v);
        @(negedge clk);
        sample_in    = s;
        sample_valid = v;
        if (v) vidx++;
    endtask

    // called right after the releasing sample has been driven
    task automatic record_beat(input logic [15:0] pkv);
        exp_t e;
        e.peak = pkv;
        if (first) begin
            e.pv   = 1'b0;
            first  = 1'b0;
        end else begin
            exp_period = 16'(pk - last_pk);
            e.pv       = 1'b1;
        end
        e.period = exp_period;
        e.at     = cyc + 1;
        last_pk  = pk;
        sb.push_back(e);
    endtask

    task automatic zeros(input int n, input bit toggle);
        for (int i = 0; i < n; i++) begin
            put(16'h0000, 1'b1);
            if (toggle) put(16'h7fff, 1'b0);
        end
    endtask

    task automatic beat_seq(input sq_t seq, input int pk_i, input int rel_i,
                            input bit exp_beat, input bit toggle);
        for (int i = 0; i < seq.size(); i++) begin
            put(seq[i], 1'b1);
            if (exp_beat && i == pk_i) pk = vidx;
            if (exp_beat && i == rel_i) record_beat(seq[pk_i]);
            if (toggle) put(16'h7fff, 1'b0);
        end
    endtask

    task automatic model_reset();
        vidx       = 0;
        last_pk    = 0;
        pk         = 0;
        first      = 1'b1;
        exp_period = 16'h0000;
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_pulse"},  {31'd0, beat_pulse}, 32'd0);
        chk({tag, "_peak"},   {16'd0, peak_value}, 32'd0);
        chk({tag, "_period"}, {16'd0, beat_period}, 32'd0);
        chk({tag, "_pv"},     {31'd0, period_valid}, 32'd0);
        chk({tag, "_lost"},   {31'd0, lost}, 32'd0);
    endtask

    initial begin
        sq_t spike6, spike5, s;
        int  n;
        logic [15:0] w;

        spike6 = '{16'h0000, 16'h5000, 16'h6000, 16'h6000, 16'h2000, 16'h0800};
        spike5 = '{16'h5000, 16'h6000, 16'h6000, 16'h2000, 16'h0800};

        rst_n        = 1'b0;
        clr          = 1'b0;
        sample_in    = 16'h0000;
        sample_valid = 1'b0;
        thresh_hi    = 16'h4000;
        thresh_lo    = 16'h1000;
        model_reset();
        repeat (3) @(negedge clk);
        chk_cleared("reset");
        rst_n = 1'b1;

        // periodic waveform, 1000-sample period, maximum 0x7800 at phase 20, released at phase 38
        for (int p = 0; p < 4; p++) begin
            for (int k = 0; k < 1000; k++) begin
                if (k <= 20)      w = 16'(k * 1536);
                else if (k <= 40) w = 16'((40 - k) * 1536);
                else              w = 16'h0000;
                put(w, 1'b1);
                if (k == 20) pk = vidx;
                if (k == 38) record_beat(16'h7800);
            end
        end
        put(16'h0000, 1'b0);
        chk("wave_period", {16'd0, beat_period}, 32'd1000);

        // synthetic spike with a tied maximum
        zeros(100, 1'b0);
        beat_seq(spike6, 2, 5, 1'b1, 1'b0);
        // arming exactly at thresh_hi
        zeros(100, 1'b0);
        s = '{16'h4000, 16'h0800};
        beat_seq(s, 0, 1, 1'b1, 1'b0);
        // sample equal to thresh_lo does not release
        zeros(100, 1'b0);
        s = '{16'h5000, 16'h1000, 16'h0fff};
        beat_seq(s, 0, 2, 1'b1, 1'b0);
        // negative sample releases (signed compare)
        zeros(100, 1'b0);
        s = '{16'h5000, 16'h9000};
        beat_seq(s, 0, 1, 1'b1, 1'b0);
        // just below thresh_hi and a large negative: no arm
        zeros(100, 1'b0);
        s = '{16'h3fff, 16'h9000, 16'h0000};
        beat_seq(s, 0, 0, 1'b0, 1'b0);
        zeros(10, 1'b0);

        // double bump inside the refractory window: one beat only
        beat_seq(spike6, 2, 5, 1'b1, 1'b0);
        zeros(20, 1'b0);
        beat_seq(spike6, 2, 5, 1'b0, 1'b0);
        zeros(100, 1'b0);

        // spikes every 300 valid samples with 50% sample_valid
        for (int b = 0; b < 4; b++) begin
            beat_seq(spike5, 1, 4, 1'b1, 1'b1);
            zeros(295, 1'b1);
        end
        put(16'h0000, 1'b0);
        chk("gap_period", {16'd0, beat_period}, 32'd300);

        // flat input until the interval counter saturates
        n = 65535 - (vidx - last_pk);
        zeros(n - 1, 1'b0);
        put(16'h0000, 1'b0);
        chk("lost_before_max", {31'd0, lost}, 32'd0);
        chk("pv_before_max", {31'd0, period_valid}, 32'd1);
        zeros(1, 1'b0);
        put(16'h0000, 1'b0);
        chk("lost_at_max", {31'd0, lost}, 32'd1);
        chk("pv_at_max", {31'd0, period_valid}, 32'd0);
        first = 1'b1;
        zeros(10, 1'b0);
        beat_seq(spike6, 2, 5, 1'b1, 1'b0);
        put(16'h0000, 1'b0);
        chk("lost_after_beat", {31'd0, lost}, 32'd0);

        // asynchronous reset while a candidate is held in PEAK
        zeros(100, 1'b0);
        put(16'h5000, 1'b1);
        put(16'h6000, 1'b1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        sample_valid = 1'b0;
        #1 chk_cleared("rst_mid_peak");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        s = '{16'h2000, 16'h0800, 16'h0000};
        beat_seq(s, 0, 0, 1'b0, 1'b0);
        zeros(5, 1'b0);
        beat_seq(spike6, 2, 5, 1'b1, 1'b0);

        // clr during REFRACT, with a valid high sample in the same cycle
        zeros(10, 1'b0);
        @(negedge clk);
        clr          = 1'b1;
        sample_in    = 16'h7000;
        sample_valid = 1'b1;
        @(negedge clk);
        clr          = 1'b0;
        sample_valid = 1'b0;
        chk_cleared("clr_refract");
        model_reset();
        beat_seq(spike5, 1, 4, 1'b1, 1'b0);
        zeros(295, 1'b0);
        beat_seq(spike5, 1, 4, 1'b1, 1'b0);

        zeros(5, 1'b0);
        repeat (3) put(16'h0000, 1'b0);
        chk("sb_empty", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
